enable_counter: RTL and testbench
=================================

Name: enable_counter

Overview:
- Free-running up-counter with a count-enable input and a terminal-count carry-out.
- Counts through 0..2^WIDTH-1 and wraps to 0.
- co flags the enabled terminal-count cycle so several instances can be cascaded, or the flag used as a stage-done strobe by a controlling FSM.
- Used as a small loop or index counter inside datapath controllers.

Parameters:
- WIDTH, 3, bit width of count; terminal count is 2^WIDTH-1 (7 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- count_enable  input  1  when 1, count advances on the next rising clk edge.
- count  output  WIDTH  current counter value (registered).
- co  output  1  carry-out; high while count is at terminal count and count_enable is 1.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n=0 forces count to 0 immediately, with no clock edge needed.
  - co is therefore 0 during reset.
  - Release is sampled at clk edges like any other input: the first increment can occur on the first rising edge after rst_n goes high with count_enable=1.
- Counting:
  - On rising clk edge with rst_n=1 and count_enable=1: count <= count + 1, modulo 2^WIDTH.
  - On rising clk edge with count_enable=0: count holds.
  - Latency is one cycle from enable to a new value on count.
- Wrap-around:
  - From 2^WIDTH-1 with count_enable=1, the next value is 0. No saturation.
  - Wrap is silent apart from co.
- Carry-out:
  - co = count_enable AND (count == 2^WIDTH-1). It is combinational from the register and the enable; no extra latency.
  - co is high in exactly the cycle whose following edge causes the wrap.
  - With count_enable=0 at terminal count, co=0 and count stays at terminal count.
- Simultaneous events: rst_n low overrides count_enable and the clock; reset always wins.
- Reset mid-count: count returns to 0 asynchronously. Counting resumes from 0 after release.
- No X propagation after reset: count is always a defined value.

Decomposition:
- No shared package needed. WIDTH is a local parameter of this block.
- The terminal-count value is derived inside the block as all-ones of WIDTH bits.
- Single module; no sub-module is natural.
- Cascading is done at the instantiating level: co of one stage drives count_enable of the next.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with count=5 -> count=0 and co=0 immediately, before the next clk edge.
- Hold: rst_n=1, count_enable=0 for 4 cycles after reset -> count stays 0, co=0.
- Count: count_enable=1 from count=0 -> count reads 1,2,...,6 on successive edges and co=0 throughout; at count=7, co=1.
- Wrap: count_enable held at 1 through count=7 -> next edge gives count=0 and co returns to 0. Continuing 8 more edges returns count to 0 again.
- Gated carry: count=7, drop count_enable to 0 -> co=0 and count stays 7 for 3 cycles. Re-enable -> co=1 immediately, then count=0 on the next edge.
- Parameter: WIDTH=4, enabled from reset -> co high only at count=15; wrap to 0 after 16 enabled edges.

Source files
------------

// File: rtl/enable_counter.sv
// Free-running modulo-2^WIDTH up-counter with a count enable and a carry-out.
// The carry-out marks the enabled terminal-count cycle, so it can drive the next stage's count_enable.
module enable_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count,
  output logic             co
);

  localparam logic [WIDTH-1:0] TERMINAL = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (count_enable) begin
      count_d = count_q + WIDTH'(1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Carry is combinational so a cascaded stage advances on the same edge as the wrap.
  assign co    = count_enable && (count_q == TERMINAL);
  assign count = count_q;

endmodule

// File: tb/tb_enable_counter.sv
// Bench for enable_counter: directed steps plus a random phase, checked against
// an integer modulo model for a WIDTH=3 and a WIDTH=4 instance driven by the same enable.
module tb_enable_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] count3;
  logic       co3;
  logic [3:0] count4;
  logic       co4;

  int passed;
  int total;
  int m3;
  int m4;

  enable_counter #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .count_enable(en), .count(count3), .co(co3)
  );

  enable_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .count_enable(en), .count(count4), .co(co4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Compare both instances against the model; the carry is expected only when
  // enabled at the all-ones value.
  task automatic check_all(input string tag);
    chk({tag, "_count3"}, 32'(count3), 32'(m3));
    chk({tag, "_co3"},    32'(co3),    32'((en && m3 == 7) ? 1 : 0));
    chk({tag, "_count4"}, 32'(count4), 32'(m4));
    chk({tag, "_co4"},    32'(co4),    32'((en && m4 == 15) ? 1 : 0));
  endtask

  // Apply an enable value for one rising edge, advance the model, then check.
  task automatic tick(input logic e, input string tag);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      m3 = (m3 + 1) % 8;
      m4 = (m4 + 1) % 16;
    end
    check_all(tag);
  endtask

  // Assert reset between edges and verify it acts without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m3 = 0;
    m4 = 0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m3     = 0;
    m4     = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) tick(1'b0, "hold");

    // Count up to terminal count; the last tick observes co=1 at 7.
    for (int i = 0; i < 7; i++) tick(1'b1, "count");
    chk("at_terminal", 32'(count3), 32'd7);
    tick(1'b1, "wrap");
    chk("wrapped_to_zero", 32'(count3), 32'd0);
    for (int i = 0; i < 8; i++) tick(1'b1, "second_lap");

    // Gated carry at terminal count.
    for (int i = 0; i < 7; i++) tick(1'b1, "to_seven");
    for (int i = 0; i < 3; i++) tick(1'b0, "gated");
    en = 1'b1;
    #1;
    chk("reenable_co", 32'(co3), 32'd1);
    tick(1'b1, "gated_wrap");

    // Reset mid-count at 5, then resume from 0.
    for (int i = 0; i < 5; i++) tick(1'b1, "to_five");
    chk("at_five", 32'(count3), 32'd5);
    async_reset("mid_reset");
    tick(1'b1, "resume");

    // Wider instance: co4 only at 15, wrap after 16 enabled edges from reset.
    async_reset("w4_reset");
    for (int i = 0; i < 16; i++) tick(1'b1, "w4_run");
    chk("w4_wrapped", 32'(count4), 32'd0);

    // Random enables with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      tick(1'(($urandom % 4) != 0), "rand");
      if (($urandom % 50) == 0) async_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
